// File: rtl/dm_responder.sv
// Data-memory responder: target end of the CPU load/store port. One request at a
// time, fixed commit latency, byte-enabled stores, registered load data.
module dm_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q;
  logic [3:0]  count_q;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  function automatic logic addr_err(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS));
  endfunction

  logic          accept;
  logic          commit;
  logic          c_write;
  logic [31:0]   c_addr;
  logic [31:0]   c_wdata;
  logic [3:0]    c_be;
  logic          c_err;
  logic [AW-1:0] c_idx;

  assign accept = (state_q == IDLE) && req_valid;
  assign commit = (accept && (LATENCY == 0)) || ((state_q == WAIT) && (count_q == 4'd0));

  // With zero latency the commit happens on the accept edge, so it must use the
  // live request; otherwise the latched copy is the only valid source.
  assign c_write = (state_q == IDLE) ? req_write : write_q;
  assign c_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign c_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign c_be    = (state_q == IDLE) ? req_be    : be_q;
  assign c_err   = addr_err(c_addr);
  assign c_idx   = c_addr[AW+1:2];

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // Storage is never reset; a store racing a reset is dropped.
  always_ff @(posedge clock) begin
    if (commit && !reset && c_write && !c_err) begin
      for (int i = 0; i < 4; i++) begin
        if (c_be[i]) mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      if (commit) begin
        err_q   <= c_err;
        rdata_q <= (!c_err && !c_write) ? mem[c_idx] : 32'd0;
      end
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
            if (LATENCY == 0) begin
              state_q <= RESP;
            end else begin
              count_q <= 4'(LATENCY - 1);
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (count_q == 4'd0) state_q <= RESP;
          else                 count_q <= count_q - 4'd1;
        end
        RESP: begin
          if (resp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: a LATENCY=2 instance for the main scenarios
// and a LATENCY=0 instance for the zero-wait timing.
module tb_dm_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  logic        d0_req_valid, d0_req_ready, d0_req_write;
  logic [31:0] d0_req_addr, d0_req_wdata;
  logic [3:0]  d0_req_be;
  logic        d0_resp_valid, d0_resp_ready, d0_resp_err;
  logic [31:0] d0_resp_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  dm_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dm_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) u_dut0 (
    .clock(clock), .reset(reset),
    .req_valid(d0_req_valid), .req_ready(d0_req_ready), .req_write(d0_req_write),
    .req_addr(d0_req_addr), .req_wdata(d0_req_wdata), .req_be(d0_req_be),
    .resp_valid(d0_resp_valid), .resp_ready(d0_resp_ready),
    .resp_rdata(d0_resp_rdata), .resp_err(d0_resp_err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Full transaction on the LATENCY=2 instance; lat = edges from accept to resp_valid.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, output logic [31:0] rd, output logic er,
                     output int lat);
    int n;
    req_write = w; req_addr = a; req_wdata = d; req_be = be; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clock); #1; n++; end
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 50) begin @(posedge clock); #1; lat++; end
    rd = resp_rdata; er = resp_err;
    @(posedge clock); #1;
  endtask

  task automatic txn0(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, output logic [31:0] rd, output logic er,
                      output int lat);
    int n;
    d0_req_write = w; d0_req_addr = a; d0_req_wdata = d; d0_req_be = be; d0_req_valid = 1'b1;
    n = 0;
    while (!d0_req_ready && n < 50) begin @(posedge clock); #1; n++; end
    @(posedge clock); #1;
    d0_req_valid = 1'b0;
    lat = 0;
    while (!d0_resp_valid && lat < 50) begin @(posedge clock); #1; lat++; end
    rd = d0_resp_rdata; er = d0_resp_err;
    @(posedge clock); #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_be = '0; resp_ready = 1'b1;
    d0_req_valid = 1'b0; d0_req_write = 1'b0; d0_req_addr = '0; d0_req_wdata = '0;
    d0_req_be = '0; d0_resp_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check_val("rst_req_ready", 32'(req_ready), 32'd1);
    check_val("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_val("rst_rdata", resp_rdata, 32'd0);
    check_val("rst_err", 32'(resp_err), 32'd0);

    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    check_val("st10_lat", 32'(lat), 32'd2);
    check_val("st10_rdata", rd, 32'd0);
    check_val("st10_err", 32'(er), 32'd0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check_val("ld10_lat", 32'(lat), 32'd2);
    check_val("ld10_rdata", rd, 32'hDEADBEEF);
    check_val("ld10_err", 32'(er), 32'd0);

    txn(1'b1, 32'h10, 32'h11223344, 4'b0101, rd, er, lat);
    txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check_val("lanes_rdata", rd, 32'hDE22BE44);

    txn(1'b1, 32'h10, 32'h0, 4'b0000, rd, er, lat);
    check_val("be0_err", 32'(er), 32'd0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check_val("be0_rdata", rd, 32'hDE22BE44);

    txn(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, er, lat);
    txn(1'b0, 32'h13, 32'h0, 4'h0, rd, er, lat);
    check_val("mis_err", 32'(er), 32'd1);
    check_val("mis_rdata", rd, 32'd0);
    txn(1'b1, 32'h1000, 32'h12345678, 4'hF, rd, er, lat);
    check_val("oor_err", 32'(er), 32'd1);
    check_val("oor_rdata", rd, 32'd0);
    txn(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    check_val("oor_word0", rd, 32'hCAFEF00D);
    check_val("oor_word0_err", 32'(er), 32'd0);

    // Backpressure with a second request held behind the first.
    resp_ready = 1'b0;
    req_write = 1'b0; req_addr = 32'h10; req_be = 4'h0; req_valid = 1'b1;
    @(posedge clock); #1;
    req_addr = 32'h0;
    n = 0;
    while (!resp_valid && n < 50) begin @(posedge clock); #1; n++; end
    check_val("bp_first_rdata", resp_rdata, 32'hDE22BE44);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      check_val("bp_hold_valid", 32'(resp_valid), 32'd1);
      check_val("bp_hold_rdata", resp_rdata, 32'hDE22BE44);
      check_val("bp_hold_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clock); #1;
    check_val("bp_idle_ready", 32'(req_ready), 32'd1);
    check_val("bp_idle_valid", 32'(resp_valid), 32'd0);
    @(posedge clock); #1;
    check_val("bp_second_accept", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 50) begin @(posedge clock); #1; n++; end
    check_val("bp_second_rdata", resp_rdata, 32'hCAFEF00D);
    @(posedge clock); #1;

    // Reset during WAIT drops the uncommitted store.
    txn(1'b1, 32'h20, 32'h5, 4'hF, rd, er, lat);
    req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h99; req_be = 4'hF; req_valid = 1'b1;
    @(posedge clock); #1;
    check_val("midwait_busy", 32'(req_ready), 32'd0);
    req_valid = 1'b0; reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check_val("midwait_rst_ready", 32'(req_ready), 32'd1);
    check_val("midwait_rst_valid", 32'(resp_valid), 32'd0);
    repeat (3) @(posedge clock);
    #1;
    txn(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    check_val("midwait_ld20", rd, 32'h5);

    // Reset and request on the same edge: reset wins.
    req_write = 1'b0; req_addr = 32'h20; req_valid = 1'b1; reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; req_valid = 1'b0;
    check_val("rst_vs_req_ready", 32'(req_ready), 32'd1);
    check_val("rst_vs_req_valid", 32'(resp_valid), 32'd0);

    txn0(1'b1, 32'h4, 32'hA5A5A5A5, 4'hF, rd, er, lat);
    check_val("lat0_st_lat", 32'(lat), 32'd0);
    check_val("lat0_st_err", 32'(er), 32'd0);
    txn0(1'b0, 32'h4, 32'h0, 4'h0, rd, er, lat);
    check_val("lat0_ld_lat", 32'(lat), 32'd0);
    check_val("lat0_ld_rdata", rd, 32'hA5A5A5A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
